// File: rtl/mbinit_param_fsm.sv
// mbinit_param_fsm: MBINIT.PARAM sub-state. Sends the local parameter request,
// answers the partner's request with the negotiated config, and checks the
// partner's response against it. Optional timeout via macro MBINIT_PARAM_TIMEOUT_EN.
// Latency: o_PARAM_end / o_param_error decode straight from the state register.
//          A received message is latched first and acted on one cycle later.
// Backpressure: the tx message holds valid/msg/data stable until i_sb_tx_ready.
//               Rx is a one-cycle strobe with no backpressure.
// Ports:
//   CLK, rst (async, active-high)
//   i_PARAM_start (level), i_local_cfg[10:0]
//   o_sb_tx_valid/o_sb_tx_msg/o_sb_tx_data <- i_sb_tx_ready
//   i_sb_rx_valid/i_sb_rx_msg/i_sb_rx_data
//   o_PARAM_end, o_param_error, o_neg_cfg[10:0]
//   cfg layout: [3:0] rate, [8:4] vswing, [9] clk mode, [10] clk phase
module mbinit_param_fsm #(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_W          = 20
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        i_PARAM_start,
    input  logic [10:0] i_local_cfg,
    output logic        o_sb_tx_valid,
    output logic [1:0]  o_sb_tx_msg,
    output logic [15:0] o_sb_tx_data,
    input  logic        i_sb_tx_ready,
    input  logic        i_sb_rx_valid,
    input  logic [1:0]  i_sb_rx_msg,
    input  logic [15:0] i_sb_rx_data,
    output logic        o_PARAM_end,
    output logic        o_param_error,
    output logic [10:0] o_neg_cfg
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND_REQ, ST_WAIT_REQ, ST_SEND_RESP, ST_WAIT_RESP, ST_DONE, ST_ERROR
    } state_t;

    localparam logic [1:0] MSG_REQ  = 2'd1;
    localparam logic [1:0] MSG_RESP = 2'd2;

    state_t      state_q, state_d;
    logic        req_seen_q, req_seen_d;
    logic        resp_seen_q, resp_seen_d;
    logic [10:0] req_dat_q, req_dat_d;
    logic [15:0] resp_dat_q, resp_dat_d;
    logic [10:0] neg_cfg_q, neg_cfg_d;

`ifdef MBINIT_PARAM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // No counter in this build; the parameters are kept for a uniform interface.
    localparam int unused_tmo_cfg = TIMEOUT_CYCLES + CNT_W;
`endif

    function automatic logic [10:0] negotiate(input logic [10:0] l, input logic [10:0] r);
        logic [3:0] rate;
        logic [4:0] vsw;
        rate = (l[3:0] < r[3:0]) ? l[3:0] : r[3:0];
        vsw  = (l[8:4] < r[8:4]) ? l[8:4] : r[8:4];
        return {l[10] & r[10], l[9] & r[9], vsw, rate};
    endfunction

    logic active;
    logic tx_acc;
    logic rx_req;
    logic rx_resp;

    assign active  = (state_q == ST_SEND_REQ) || (state_q == ST_WAIT_REQ) ||
                     (state_q == ST_SEND_RESP) || (state_q == ST_WAIT_RESP);
    assign tx_acc  = o_sb_tx_valid && i_sb_tx_ready;
    assign rx_req  = i_sb_rx_valid && (i_sb_rx_msg == MSG_REQ);
    assign rx_resp = i_sb_rx_valid && (i_sb_rx_msg == MSG_RESP);

    always_comb begin
        state_d     = state_q;
        req_seen_d  = req_seen_q;
        resp_seen_d = resp_seen_q;
        req_dat_d   = req_dat_q;
        resp_dat_d  = resp_dat_q;
        neg_cfg_d   = neg_cfg_q;
`ifdef MBINIT_PARAM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE:      if (i_PARAM_start) state_d = ST_SEND_REQ;
            ST_SEND_REQ:  if (tx_acc) state_d = ST_WAIT_REQ;
            ST_WAIT_REQ: begin
                if (req_seen_q) begin
                    neg_cfg_d = negotiate(i_local_cfg, req_dat_q);
                    state_d   = ST_SEND_RESP;
                end
            end
            ST_SEND_RESP: if (tx_acc) state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (resp_seen_q) begin
                    if ((resp_dat_q[15:11] == 5'd0) && (resp_dat_q[10:0] == neg_cfg_q))
                        state_d = ST_DONE;
                    else
                        state_d = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: if (!i_PARAM_start) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // A message may overwrite its latch only until the consuming state acts on it.
        if (active) begin
            if (rx_req && ((state_q == ST_SEND_REQ) ||
                           ((state_q == ST_WAIT_REQ) && !req_seen_q))) begin
                req_seen_d = 1'b1;
                req_dat_d  = i_sb_rx_data[10:0];
            end
            if (rx_resp && !((state_q == ST_WAIT_RESP) && resp_seen_q)) begin
                resp_seen_d = 1'b1;
                resp_dat_d  = i_sb_rx_data;
            end
        end

`ifdef MBINIT_PARAM_TIMEOUT_EN
        // Timeout overrides whatever transition the case above chose.
        if (active) begin
            if (cnt_q == CNT_LAST)
                state_d = ST_ERROR;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
`endif

        // Abort overrides everything, including timeout.
        if (active && !i_PARAM_start)
            state_d = ST_IDLE;

        // IDLE always starts clean: flags, payloads, counter and result cleared.
        if (state_d == ST_IDLE) begin
            req_seen_d  = 1'b0;
            resp_seen_d = 1'b0;
            req_dat_d   = '0;
            resp_dat_d  = '0;
            neg_cfg_d   = '0;
`ifdef MBINIT_PARAM_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_seen_q  <= 1'b0;
            resp_seen_q <= 1'b0;
            req_dat_q   <= '0;
            resp_dat_q  <= '0;
            neg_cfg_q   <= '0;
`ifdef MBINIT_PARAM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_seen_q  <= req_seen_d;
            resp_seen_q <= resp_seen_d;
            req_dat_q   <= req_dat_d;
            resp_dat_q  <= resp_dat_d;
            neg_cfg_q   <= neg_cfg_d;
`ifdef MBINIT_PARAM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Valid is gated by start combinationally so an abort withdraws it at once.
    assign o_sb_tx_valid = i_PARAM_start &&
                           ((state_q == ST_SEND_REQ) || (state_q == ST_SEND_RESP));
    assign o_sb_tx_msg   = (state_q == ST_SEND_REQ)  ? MSG_REQ  :
                           (state_q == ST_SEND_RESP) ? MSG_RESP : 2'd0;
    assign o_sb_tx_data  = (state_q == ST_SEND_REQ)  ? {5'd0, i_local_cfg} :
                           (state_q == ST_SEND_RESP) ? {5'd0, neg_cfg_q}   : 16'd0;
    assign o_PARAM_end   = (state_q == ST_DONE);
    assign o_param_error = (state_q == ST_ERROR);
    assign o_neg_cfg     = neg_cfg_q;

endmodule

// File: tb/tb_mbinit_param_fsm.sv
// tb_mbinit_param_fsm: directed vectors for mbinit_param_fsm.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
// Works with MBINIT_PARAM_TIMEOUT_EN defined or undefined (TIMEOUT_CYCLES = 50).
module tb_mbinit_param_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] lcfg = '0;
    logic        tx_rdy = 1'b0;
    logic        rx_vld = 1'b0;
    logic [1:0]  rx_msg = '0;
    logic [15:0] rx_dat = '0;
    logic        tx_vld;
    logic [1:0]  tx_msg;
    logic [15:0] tx_dat;
    logic        p_end;
    logic        p_err;
    logic [10:0] neg;

    int n_chk = 0;
    int n_err = 0;

    mbinit_param_fsm #(.TIMEOUT_CYCLES(50), .CNT_W(20)) dut (
        .CLK(clk), .rst(rst), .i_PARAM_start(start), .i_local_cfg(lcfg),
        .o_sb_tx_valid(tx_vld), .o_sb_tx_msg(tx_msg), .o_sb_tx_data(tx_dat),
        .i_sb_tx_ready(tx_rdy), .i_sb_rx_valid(rx_vld), .i_sb_rx_msg(rx_msg),
        .i_sb_rx_data(rx_dat), .o_PARAM_end(p_end), .o_param_error(p_err),
        .o_neg_cfg(neg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [10:0] lcl;
        logic [10:0] rmt;
        logic [10:0] exp;
    } vec_t;

    vec_t vt [5];

    function automatic logic [10:0] mk(input int rate, input int vsw, input int mode, input int ph);
        logic [3:0] r4;
        logic [4:0] v5;
        r4 = 4'(rate);
        v5 = 5'(vsw);
        return {ph[0], mode[0], v5, r4};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tx(input string nm, input logic [1:0] msg);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (tx_vld && tx_msg == msg) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic wait_outcome(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (p_end || p_err) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic rx_pulse(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        rx_vld = 1'b1; rx_msg = m; rx_dat = d;
        @(negedge clk);
        rx_vld = 1'b0; rx_msg = '0; rx_dat = '0;
    endtask

    task automatic drop_start(input string nm);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        chk(nm, {29'd0, p_end, p_err, tx_vld}, 32'd0);
        chk({nm, "_neg"}, 32'(neg), 32'd0);
    endtask

    // Full handshake; ok selects whether DONE or ERROR is required.
    task automatic run_flow(input string nm, input vec_t v, input logic [15:0] resp, input bit ok);
        @(negedge clk);
        lcfg = v.lcl; tx_rdy = 1'b1; start = 1'b1;
        wait_tx({nm, "_req_tx"}, 2'd1);
        chk({nm, "_req_dat"}, 32'(tx_dat), 32'({5'd0, v.lcl}));
        rx_pulse(2'd1, {5'd0, v.rmt});
        wait_tx({nm, "_resp_tx"}, 2'd2);
        chk({nm, "_resp_dat"}, 32'(tx_dat), 32'({5'd0, v.exp}));
        rx_pulse(2'd2, resp);
        wait_outcome({nm, "_outcome"});
        chk({nm, "_end_err"}, {30'd0, p_end, p_err}, ok ? 32'd2 : 32'd1);
        chk({nm, "_neg"}, 32'(neg), 32'(v.exp));
        drop_start({nm, "_idle"});
    endtask

    int k;

    initial begin
        vt[0] = '{mk(4, 10, 1, 1), mk(3, 12, 1, 0), mk(3, 10, 1, 0)};
        vt[1] = '{mk(15, 31, 1, 1), mk(15, 31, 1, 1), mk(15, 31, 1, 1)};
        vt[2] = '{mk(0, 0, 0, 0), mk(9, 20, 1, 1), mk(0, 0, 0, 0)};
        vt[3] = '{mk(7, 3, 1, 0), mk(2, 17, 0, 1), mk(2, 3, 0, 0)};
        vt[4] = '{mk(5, 16, 0, 1), mk(5, 16, 1, 1), mk(5, 16, 0, 1)};

        // Reset state
        @(negedge clk); #1;
        chk("reset_outputs", {tx_vld, tx_msg, tx_dat, p_end, p_err, neg}, 32'd0);
        rst = 1'b0;

        // Normal flow over the vector table
        for (int i = 0; i < 5; i++)
            run_flow($sformatf("vec%0d", i), vt[i], {5'd0, vt[i].exp}, 1'b1);

        // Early req and resp captured while the request is backpressured
        @(negedge clk);
        lcfg = vt[0].lcl; tx_rdy = 1'b0; start = 1'b1;
        wait_tx("early_req_tx", 2'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("early_hold%0d", c), {13'd0, tx_vld, tx_msg, tx_dat},
                {13'd0, 1'b1, 2'd1, 5'd0, vt[0].lcl});
            rx_vld = (c == 1) || (c == 3);
            rx_msg = (c == 1) ? 2'd1 : 2'd2;
            rx_dat = (c == 1) ? {5'd0, vt[0].rmt} : {5'd0, vt[0].exp};
            @(negedge clk); #1;
            rx_vld = 1'b0; rx_msg = '0; rx_dat = '0;
        end
        tx_rdy = 1'b1;
        wait_tx("early_resp_tx", 2'd2);
        chk("early_resp_dat", 32'(tx_dat), 32'({5'd0, vt[0].exp}));
        wait_outcome("early_outcome");
        chk("early_end_err", {30'd0, p_end, p_err}, 32'd2);
        chk("early_neg", 32'(neg), 32'(vt[0].exp));
        drop_start("early_idle");

        // Response mismatch: wrong rate, then nonzero reserved bits
        run_flow("mis_rate", vt[0], {5'd0, mk(5, 10, 1, 0)}, 1'b0);
        run_flow("mis_rsvd", vt[0], {5'b00001, vt[0].exp}, 1'b0);

`ifdef MBINIT_PARAM_TIMEOUT_EN
        // Timeout: ERROR 50 cycles after leaving IDLE with no rx traffic
        @(negedge clk);
        lcfg = vt[0].lcl; tx_rdy = 1'b1; start = 1'b1;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk); #1;
            if (p_err) break;
        end
        chk("tmo_cycles", 32'(k - 1), 32'd50);
        chk("tmo_end", 32'(p_end), 32'd0);
        drop_start("tmo_idle");
`else
        // No timeout: still waiting for the request after 1000 cycles
        @(negedge clk);
        lcfg = vt[0].lcl; tx_rdy = 1'b1; start = 1'b1;
        for (k = 0; k < 1000; k++) @(negedge clk);
        #1;
        chk("notmo_wait", {29'd0, p_end, p_err, tx_vld}, 32'd0);
        rx_pulse(2'd1, {5'd0, vt[0].rmt});
        wait_tx("notmo_resp_tx", 2'd2);
        drop_start("notmo_idle");
`endif

        // Abort in SEND_RESP with valid high
        @(negedge clk);
        lcfg = vt[0].lcl; tx_rdy = 1'b1; start = 1'b1;
        wait_tx("abort_req_tx", 2'd1);
        rx_pulse(2'd1, {5'd0, vt[0].rmt});
        tx_rdy = 1'b0;
        wait_tx("abort_resp_tx", 2'd2);
        chk("abort_neg_before", 32'(neg), 32'(vt[0].exp));
        start = 1'b0; #1;
        chk("abort_vld_comb", 32'(tx_vld), 32'd0);
        @(negedge clk); #1;
        chk("abort_idle", {16'd0, tx_msg, p_end, p_err, neg}, 32'd0);
        run_flow("restart", vt[3], {5'd0, vt[3].exp}, 1'b1);

        // Asynchronous reset in WAIT_RESP
        @(negedge clk);
        lcfg = vt[0].lcl; tx_rdy = 1'b1; start = 1'b1;
        wait_tx("rst_req_tx", 2'd1);
        rx_pulse(2'd1, {5'd0, vt[0].rmt});
        wait_tx("rst_resp_tx", 2'd2);
        @(negedge clk); #1;
        chk("rst_neg_before", 32'(neg), 32'(vt[0].exp));
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {tx_vld, tx_msg, tx_dat, p_end, p_err, neg}, 32'd0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_idle", {tx_vld, tx_msg, tx_dat, p_end, p_err, neg}, 32'd0);
        @(negedge clk); #1;
        chk("rst_restart", {29'd0, tx_vld, tx_msg}, 32'd5);
        drop_start("rst_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mbinit_param_fsm.md
Name: mbinit_param_fsm

Overview:
- Executes the MBINIT.PARAM sub-state of mainband initialization.
- Sits directly downstream of the MBINIT sequencer: consumes its level-high PARAM start and returns the PARAM end handshake.
- Exchanges the parameter configuration request and response with the link partner over the sideband message interface.
- Resolves and holds the negotiated data rate, voltage swing and clock settings for later MBINIT stages.

Parameters:
TIMEOUT_CYCLES, 800000, CLK cycles from start to forced error (8 ms at 100 MHz)
CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
CLK  in  1  block clock
rst  in  1  asynchronous reset, active-high
i_PARAM_start  in  1  level; high for the whole PARAM sub-state; drop = abort/finish
i_local_cfg  in  11  [3:0] max rate, [8:4] vswing, [9] clk mode, [10] clk phase; stable while start high
o_sb_tx_valid  out  1  sideband message valid
o_sb_tx_msg  out  2  1 = PARAM_REQ, 2 = PARAM_RESP
o_sb_tx_data  out  16  payload
i_sb_tx_ready  in  1  sideband accepts when valid & ready
i_sb_rx_valid  in  1  one-cycle received-message strobe
i_sb_rx_msg  in  2  received message code
i_sb_rx_data  in  16  received payload
o_PARAM_end  out  1  PARAM completed successfully
o_param_error  out  1  timeout or response mismatch
o_neg_cfg  out  11  negotiated config, same field layout as i_local_cfg

Behaviour:
- Reset: all outputs 0, state IDLE, sticky flags and counter cleared.
- Payload layout: [10:0] = cfg fields, [15:11] = 0.
- Negotiation rules:
  - rate = min(local, remote)
  - vswing = min(local, remote)
  - clk mode = local & remote
  - clk phase = local & remote
- Sticky capture: in any non-IDLE state, i_sb_rx_valid with msg=1 sets req_seen and latches the remote req payload; msg=2 sets resp_seen and latches the resp payload.
  - Messages arriving in IDLE, DONE or ERROR are ignored.
  - Messages with msg=0 or 3 are ignored.
- State IDLE: when start = 1, go to SEND_REQ next cycle and clear the counter.
- State SEND_REQ:
  - o_sb_tx_valid = 1, msg = 1, data = local cfg.
  - On valid & ready, go to WAIT_REQ.
  - Valid, msg and data stay stable until accepted.
- State WAIT_REQ: on req_seen (including captured earlier), compute and register o_neg_cfg, then go to SEND_RESP.
- State SEND_RESP: tx msg = 2, data = o_neg_cfg; on accept, go to WAIT_RESP.
- State WAIT_RESP: on resp_seen, check resp payload[10:0].
  - Match with o_neg_cfg: go to DONE.
  - Mismatch or nonzero [15:11]: go to ERROR.
  - A resp already captured during SEND_REQ/WAIT_REQ counts; it is checked here.
- State DONE: o_PARAM_end = 1 and o_neg_cfg held; when start = 0, go to IDLE.
- State ERROR: o_param_error = 1; when start = 0, go to IDLE.
- Output timing: o_PARAM_end and o_param_error decode directly from the state register, no extra latency.
- Start drop in any active state: return to IDLE next cycle.
  - o_sb_tx_valid drops immediately (combinational on start).
  - Flags and counter clear; o_neg_cfg clears.
- Simultaneous events: rx strobe in the same cycle as a tx accept is captured normally.
- Duplicate messages: a repeated req or resp overwrites the latched payload only before that message has been consumed by its state.
- Timeout: counter increments every cycle in SEND_REQ..WAIT_RESP. At count == TIMEOUT_CYCLES-1, go to ERROR; timeout wins over any same-cycle transition.
- Mid-operation reset: immediate return to the reset values above.

Optional Feature:
MBINIT_PARAM_TIMEOUT_EN
- Defined: the timeout counter and timeout→ERROR transition exist as specified.
- Undefined: no counter is synthesized; the block waits indefinitely; ERROR is reachable only by response mismatch.

Test Plan:
1. Normal flow
   - Stimulus: local cfg rate 4/vswing 10/mode 1/phase 1; remote req rate 3/vswing 12/mode 1/phase 0; tx_ready = 1; matching resp.
   - Response: o_neg_cfg = rate 3, vswing 10, mode 1, phase 0; o_PARAM_end = 1 until start drops, then IDLE.
2. Early messages
   - Stimulus: remote req and remote resp both arrive during SEND_REQ while tx_ready is held 0 for 5 cycles.
   - Response: req is held stable for 5 cycles; after ready, SEND_RESP follows; DONE is reached without further rx.
3. Response mismatch
   - Stimulus: resp carries rate 5 where negotiated rate is 3.
   - Response: o_param_error = 1, o_PARAM_end = 0; IDLE after start drops.
4. Timeout (macro defined, TIMEOUT_CYCLES = 50)
   - Stimulus: no rx traffic.
   - Response: ERROR entered exactly 50 cycles after leaving IDLE.
   - Macro undefined: still in WAIT_REQ after 1000 cycles.
5. Abort
   - Stimulus: drop start in SEND_RESP with tx_valid high.
   - Response: tx_valid = 0 the same cycle; IDLE next cycle; o_neg_cfg = 0; a restart repeats the full flow cleanly.
6. Reset
   - Stimulus: assert rst in WAIT_RESP.
   - Response: all outputs 0 asynchronously; IDLE after release.
